// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache sitting between the fetch stage
// and the memory controller. Hits are answered combinationally from the frame
// array. A miss issues one single-word read and fills the frame, and the
// fetch stage then sees the hit in the following IDLE cycle.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | serve hits; a requested miss latches its word address
// FETCH | memory read of miss_addr outstanding; fill when iwait drops
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state;

    // Word address of the outstanding miss, {tag, index}.
    logic [29:0] miss_addr;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tag_mem  [SETS];
    logic [31:0]     data_mem [SETS];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] fill_tag;
    logic [IW-1:0] fill_idx;
    logic          hit;
    logic          fill;
    logic [1:0]    unused_byte_offset;

    assign req_tag  = imemaddr[31:IW+2];
    assign req_idx  = imemaddr[IW+1:2];
    assign fill_tag = miss_addr[29:IW];
    assign fill_idx = miss_addr[IW-1:0];

    // Byte offset within the word never affects the lookup.
    assign unused_byte_offset = imemaddr[1:0];

    // Lookup only counts in IDLE; FETCH ignores the datapath entirely.
    assign hit  = (state == IDLE) && imemREN && valid[req_idx]
                  && (tag_mem[req_idx] == req_tag);
    assign fill = (state == FETCH) && !iwait;

    // Datapath and memory-side outputs, all derived from registered state so
    // an asynchronous reset drops iREN at once.
    always_comb begin
        ihit     = hit;
        imemload = hit ? data_mem[req_idx] : 32'd0;
        iREN     = (state == FETCH);
        iaddr    = (state == FETCH) ? {miss_addr, 2'b00} : 32'd0;
    end

    // Two-state miss controller; miss_addr is frozen for the whole FETCH.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        miss_addr <= {req_tag, req_idx};
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid bits: cleared by reset, set by a completed fill.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data are meaningless while invalid, so they carry no reset.
    // A fill overwrites the frame unconditionally (conflict eviction).
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run,
// all compared against a per-frame reference model keyed by word address.
module tb_icache;

    localparam int SETS = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each frame holds, and its word.
    bit          m_valid [SETS];
    logic [29:0] m_wa    [SETS];
    logic [31:0] m_data  [SETS];

    icache #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int frame_of(input logic [29:0] wa);
        return int'(wa % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        logic [29:0] wa;
        wa = addr[31:2];
        return m_valid[frame_of(wa)] && (m_wa[frame_of(wa)] == wa);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [29:0] wa;
        wa = addr[31:2];
        return m_data[frame_of(wa)];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endtask

    // Outstanding fetch of addr: iwait held for lat-1 cycles, then word
    // delivered. Afterwards the cycle following the fill is checked against
    // the address the datapath presents then (addr, or alt if use_alt).
    task automatic fetch_phase(input logic [31:0] addr, input int lat,
                               input logic [31:0] word, input bit use_alt,
                               input logic [31:0] alt);
        logic [31:0] cur;
        bit          exp_hit;
        for (int c = 1; c <= lat; c++) begin
            @(posedge CLK); #1;
            if (use_alt) imemaddr = alt;
            iwait = (c < lat);
            iload = (c < lat) ? $urandom : word;
            @(negedge CLK);
            checks++;
            if (iREN !== 1'b1) begin
                errors++;
                $display("FAIL fetch_iren addr=%h cyc=%0d got %b want 1", addr, c, iREN);
            end
            checks++;
            if (iaddr !== {addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL fetch_iaddr cyc=%0d got %h want %h", c, iaddr, {addr[31:2], 2'b00});
            end
            checks++;
            if (ihit !== 1'b0 || imemload !== 32'd0) begin
                errors++;
                $display("FAIL fetch_quiet cyc=%0d got ihit=%b load=%h want 0/0", c, ihit, imemload);
            end
        end
        m_valid[frame_of(addr[31:2])] = 1'b1;
        m_wa[frame_of(addr[31:2])]    = addr[31:2];
        m_data[frame_of(addr[31:2])]  = word;
        @(posedge CLK); #1;
        iwait = 1'b1;
        iload = $urandom;
        cur = use_alt ? alt : addr;
        exp_hit = model_hit(cur);
        @(negedge CLK);
        checks++;
        if (ihit !== exp_hit) begin
            errors++;
            $display("FAIL post_fill_hit addr=%h got %b want %b", cur, ihit, exp_hit);
        end
        checks++;
        if (imemload !== (exp_hit ? model_word(cur) : 32'd0)) begin
            errors++;
            $display("FAIL post_fill_load addr=%h got %h want %h", cur, imemload,
                     exp_hit ? model_word(cur) : 32'd0);
        end
        checks++;
        if (iREN !== 1'b0) begin
            errors++;
            $display("FAIL post_fill_iren got %b want 0", iREN);
        end
    endtask

    // One datapath read: cycle 0 lookup, then a full fetch if it misses.
    task automatic do_read(input logic [31:0] addr, input int lat,
                           input logic [31:0] word, input bit use_alt,
                           input logic [31:0] alt);
        bit exp_hit;
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = $urandom;
        exp_hit  = model_hit(addr);
        @(negedge CLK);
        checks++;
        if (ihit !== exp_hit) begin
            errors++;
            $display("FAIL lookup_hit addr=%h got %b want %b", addr, ihit, exp_hit);
        end
        checks++;
        if (imemload !== (exp_hit ? model_word(addr) : 32'd0)) begin
            errors++;
            $display("FAIL lookup_load addr=%h got %h want %h", addr, imemload,
                     exp_hit ? model_word(addr) : 32'd0);
        end
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'd0) begin
            errors++;
            $display("FAIL lookup_mem_idle addr=%h got iREN=%b iaddr=%h want 0/0", addr, iREN, iaddr);
        end
        if (!exp_hit) fetch_phase(addr, lat, word, use_alt, alt);
    endtask

    task automatic idle_cycle();
        @(posedge CLK); #1;
        imemREN  = 1'b0;
        imemaddr = $urandom;
        iwait    = $urandom_range(0, 1);
        iload    = $urandom;
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'd0 || iREN !== 1'b0 || iaddr !== 32'd0) begin
            errors++;
            $display("FAIL no_request got ihit=%b load=%h iREN=%b iaddr=%h want all 0",
                     ihit, imemload, iREN, iaddr);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        imemREN = 1'b1;
        imemaddr = 32'h0;
        iwait = 1'b1;
        iload = 32'h0;
        model_clear();
        repeat (2) @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'd0 || iREN !== 1'b0 || iaddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got ihit=%b load=%h iREN=%b iaddr=%h want all 0",
                     ihit, imemload, iREN, iaddr);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        imemREN = 1'b0;
    endtask

    task automatic test_cold_miss();
        do_read(32'h0000_0000, 2, 32'hA5A5_0001, 1'b0, 32'h0);
        do_read(32'h0000_0004, 4, 32'h8C22_0000, 1'b0, 32'h0);
    endtask

    task automatic test_rehit();
        do_read(32'h0000_0004, 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        do_read(32'h0000_0007, 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        checks++;
        if (imemload !== 32'h8C22_0000) begin
            errors++;
            $display("FAIL rehit_word got %h want 8c220000", imemload);
        end
    endtask

    task automatic test_conflict();
        do_read(32'h0000_0040, 1, 32'h1111_1111, 1'b0, 32'h0);
        do_read(32'h0000_0000, 1, 32'h2222_2222, 1'b0, 32'h0);
        do_read(32'h0000_0040, 2, 32'h3333_3333, 1'b0, 32'h0);
        checks++;
        if (imemload !== 32'h3333_3333) begin
            errors++;
            $display("FAIL conflict_refill got %h want 33333333", imemload);
        end
    endtask

    task automatic test_addr_change();
        do_read(32'h0000_0010, 3, 32'h0BAD_F00D, 1'b1, 32'h0000_0020);
        fetch_phase(32'h0000_0020, 2, 32'h2020_2020, 1'b0, 32'h0);
        do_read(32'h0000_0010, 1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        checks++;
        if (imemload !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL addr_change_frame4 got %h want 0badf00d", imemload);
        end
    endtask

    task automatic test_reset_during_fetch();
        logic [31:0] a;
        a = 32'h0000_1234 & ~32'h3;
        do_read(32'h0000_0008, 1, 32'h0808_0808, 1'b0, 32'h0);
        @(posedge CLK); #1;
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        @(posedge CLK); #1;
        iwait = 1'b0;
        iload = 32'h7777_7777;
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort got iREN=%b iaddr=%h want 0/0", iREN, iaddr);
        end
        model_clear();
        @(posedge CLK); #1;
        nRST = 1'b1;
        imemREN = 1'b0;
        iwait = 1'b1;
        do_read(a, 1, 32'h5555_AAAA, 1'b0, 32'h0);
        do_read(32'h0000_0008, 1, 32'h0909_0909, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle_cycle();
            end else begin
                a = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0,
                     8'($urandom_range(0, 255))};
                do_read(a, $urandom_range(1, 4), $urandom, 1'b0, 32'h0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_rehit();
        test_conflict();
        test_addr_change();
        test_reset_during_fetch();
        idle_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
